branch_stall_ctrl: RTL

Sequencing controller for control-flow hazards in the 5-stage pipeline. It detects a branch or jump opcode in IF/ID, freezes fetch and feeds bubbles into IF/ID until the EX stage resolves the instruction, then either redirects the PC or resumes sequential fetch. It sits between the hazard-detection logic and the PC / IF/ID pipeline-register enables. A watchdog recovers from a missing resolution.

---
 rtl/branch_ctrl_pkg.sv | 20 ++
 rtl/ctrl_opcode_decode.sv | 20 ++
 rtl/branch_stall_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared constants and types for the branch/jump stall controller.
package branch_ctrl_pkg;

  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Classifies an IF/ID opcode as a conditional branch or an unconditional jump.
module ctrl_opcode_decode
  import branch_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_branch,
  output logic       is_jump
);

  always_comb begin
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (opcode)
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: is_branch = 1'b1;
      OP_J, OP_JR, OP_JAL, OP_JALR:       is_jump   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_stall_ctrl.sv
// Freezes fetch and bubbles IF/ID from control-instruction detect until EX resolves it.
// Optional counters stall_cycles/redirects are built when BRANCH_STALL_STATS_EN is defined.
module branch_stall_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  opcode_id,
  input  logic        valid_id,
  input  logic        resolve_ex,
  input  logic        taken_ex,
  input  logic        mem_stall,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        pc_redirect,
  output logic        busy,
  output logic        timeout
`ifdef BRANCH_STALL_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] redirects
`endif
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(MAX_WAIT - 1);

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic                  is_jump_q, is_jump_nxt;
  logic                  is_branch, is_jump, is_ctrl;

  ctrl_opcode_decode u_decode (
    .opcode    (opcode_id),
    .is_branch (is_branch),
    .is_jump   (is_jump)
  );

  assign is_ctrl = valid_id & (is_branch | is_jump);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      is_jump_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      is_jump_q <= is_jump_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    is_jump_nxt  = is_jump_q;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    pc_redirect  = 1'b0;
    busy         = 1'b0;
    timeout      = 1'b0;

    // Outputs are forced quiet for the whole reset assertion, including mid-WAIT aborts.
    if (!rst) begin
      state_nxt = RUN;
    end else if (mem_stall) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      busy      = (state == WAIT);
    end else begin
      case (state)
        RUN: begin
          if (is_ctrl) begin
            pc_hold      = 1'b1;
            ifid_flush   = 1'b1;
            is_jump_nxt  = is_jump;
            wait_cnt_nxt = '0;
            state_nxt    = WAIT;
          end
        end
        WAIT: begin
          pc_hold      = 1'b1;
          ifid_flush   = 1'b1;
          busy         = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
          // Resolve takes priority over a watchdog expiry in the same cycle.
          if (resolve_ex) begin
            pc_hold     = 1'b0;
            pc_redirect = is_jump_q | taken_ex;
            state_nxt   = RUN;
          end else if (wait_cnt == LAST_CNT) begin
            timeout   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef BRANCH_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      redirects    <= '0;
    end else begin
      if (pc_hold && !mem_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 16'd1;
      if (pc_redirect && redirects != '1)
        redirects <= redirects + 16'd1;
    end
  end
`endif

endmodule
